// File: rtl/ps2_key_scheduler.sv
// ps2_key_scheduler
//   Turns the PS/2 scancode-set-2 byte stream into per-player held-key
//   vectors and a small queue of press/release events for the game logic.
//   The prefix sequencer handles the E0 extended prefix, the F0 break prefix
//   and the 8-byte E1 pause sequence. A prefix that waits too long for its
//   next byte is abandoned.
//
// Parameters
//   FIFO_DEPTH      event FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  clk cycles a pending prefix may wait for its next byte
//
// Build option
//   KEY_REPEAT_FILTER_EN  when defined, a make for a key that is already held,
//                         or a break for a key that is already released,
//                         produces no event. Key vectors are updated the same
//                         way in both builds.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   byte_in/byte_valid  received byte and its one-cycle strobe
//   p1_keys, p2_keys    held keys {bomb,right,left,down,up}
//   event_*             head of the event FIFO (registered outputs)
//   event_ready         consumer pops the head when event_valid && event_ready
//   overflow            one-cycle pulse when an event is dropped on a full FIFO
//   proto_err           one-cycle pulse on a prefix timeout or an error byte
//
// Handshake: an event transfers in a cycle where event_valid && event_ready
// are both high at the rising edge. The head fields hold their values while
// event_valid && !event_ready.
//
// The sequencer state is available to checkers as the internal signal
// 'state' (type state_t).
module ps2_key_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [4:0] p1_keys,
  output logic [4:0] p2_keys,
  output logic       event_valid,
  output logic       event_player,
  output logic [2:0] event_key,
  output logic       event_press,
  input  logic       event_ready,
  output logic       overflow,
  output logic       proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t           state;
  logic [2:0]       skip_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Decode request for the byte arriving this cycle
  logic       do_decode;
  logic       dec_ext;
  logic       dec_press;
  logic       map_hit;
  logic       map_player;
  logic [2:0] map_key;
  logic       cur_bit;
  logic       push_req;

  always_comb begin
    do_decode = 1'b0;
    dec_ext   = 1'b0;
    dec_press = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          case (byte_in)
            8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE: ;
            default: begin
              do_decode = 1'b1;
              dec_press = 1'b1;
            end
          endcase
        end
        EXT: begin
          if (byte_in != 8'hF0) begin
            do_decode = 1'b1;
            dec_ext   = 1'b1;
            dec_press = 1'b1;
          end
        end
        BRK:     do_decode = 1'b1;
        EXT_BRK: begin
          do_decode = 1'b1;
          dec_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Key map: P1 on plain letter keys, P2 on extended arrows plus Enter (5A)
  always_comb begin
    map_hit    = 1'b1;
    map_player = 1'b0;
    map_key    = 3'd0;
    case ({dec_ext, byte_in})
      9'h01D: map_key = 3'd0;
      9'h01B: map_key = 3'd1;
      9'h01C: map_key = 3'd2;
      9'h023: map_key = 3'd3;
      9'h029: map_key = 3'd4;
      9'h05A: begin map_player = 1'b1; map_key = 3'd4; end
      9'h175: begin map_player = 1'b1; map_key = 3'd0; end
      9'h172: begin map_player = 1'b1; map_key = 3'd1; end
      9'h16B: begin map_player = 1'b1; map_key = 3'd2; end
      9'h174: begin map_player = 1'b1; map_key = 3'd3; end
      default: map_hit = 1'b0;
    endcase
  end

  assign cur_bit = map_player ? p2_keys[map_key] : p1_keys[map_key];

`ifdef KEY_REPEAT_FILTER_EN
  assign push_req = do_decode && map_hit && (cur_bit != dec_press);
`else
  assign push_req = do_decode && map_hit;
`endif

  // Prefix sequencer, timeout and held-key vectors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      skip_cnt  <= 3'd0;
      tmo_cnt   <= '0;
      p1_keys   <= 5'd0;
      p2_keys   <= 5'd0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (byte_valid) begin
        // A byte always beats a coincident timeout
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            case (byte_in)
              8'hE0: state <= EXT;
              8'hF0: state <= BRK;
              8'hE1: begin
                state    <= SKIP;
                skip_cnt <= 3'd7;
              end
              8'h00, 8'hFF: proto_err <= 1'b1;
              default: ;
            endcase
          end
          EXT:     state <= (byte_in == 8'hF0) ? EXT_BRK : IDLE;
          BRK:     state <= IDLE;
          EXT_BRK: state <= IDLE;
          SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        if (do_decode && map_hit) begin
          if (map_player) p2_keys[map_key] <= dec_press;
          else            p1_keys[map_key] <= dec_press;
        end
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state     <= IDLE;
          skip_cnt  <= 3'd0;
          tmo_cnt   <= '0;
          proto_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

  // Event FIFO: entry = {player, key[2:0], press}
  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [4:0]       push_entry;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_next;
  logic [4:0]       head_next;

  assign push_entry = {map_player, map_key, dec_press};

  always_comb begin
    pop             = event_valid && event_ready;
    full            = (count == CNT_W'(FIFO_DEPTH));
    push_ok         = push_req && (!full || pop);
    rd_next         = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_after_pop = count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push_ok);
    // The head register is loaded with whatever will sit at rd_next; when the
    // queue drains to empty in the same cycle as a push, that is the new entry.
    if (count_next == '0)           head_next = 5'd0;
    else if (count_after_pop == '0) head_next = push_entry;
    else                            head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      event_valid  <= 1'b0;
      event_player <= 1'b0;
      event_key    <= 3'd0;
      event_press  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr       <= rd_next;
      count        <= count_next;
      event_valid  <= (count_next != '0);
      event_player <= head_next[4];
      event_key    <= head_next[3:1];
      event_press  <= head_next[0];
      overflow     <= push_req && full && !pop;
    end
  end

endmodule

// File: doc/ps2_key_scheduler.md
Name: ps2_key_scheduler

Overview:
- Sits between the PS/2 byte receiver and the Bomberman game logic, in the system clock domain.
- Sequences the scancode-set-2 protocol: E0 extended prefix, F0 break prefix and the E1 pause sequence.
- Maps codes to two players' action keys, keeps a live pressed-key vector per player, and queues press/release events in a small FIFO that game logic drains with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 2_500_000, clk cycles a pending prefix may wait for its next byte before being abandoned (50 ms at 50 MHz)

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- byte_in  input  8  received scancode byte, valid only with byte_valid
- byte_valid  input  1  one-cycle strobe, byte_in is a complete, parity-checked byte
- p1_keys  output  5  player 1 held keys {bomb,right,left,down,up}
- p2_keys  output  5  player 2 held keys, same order
- event_valid  output  1  FIFO non-empty
- event_player  output  1  0 = P1, 1 = P2 (head entry)
- event_key  output  3  0 up, 1 down, 2 left, 3 right, 4 bomb
- event_press  output  1  1 = make, 0 = break
- event_ready  input  1  consumer pops the head when event_valid && event_ready
- overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full
- proto_err  output  1  one-cycle pulse on a prefix timeout or a keyboard error byte (00 or FF)

Behaviour:
- Reset values: p1_keys = p2_keys = 0, FIFO empty, event_valid = event_player = event_key = event_press = 0, overflow = proto_err = 0, FSM in IDLE, timeout counter = 0.
- FSM states and transitions on byte_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip count 7; 00 or FF -> pulse proto_err, stay; AA, FA and FE -> ignore; any other byte -> decode as make (non-extended).
  - EXT: F0 -> EXT_BRK; other -> decode as make (extended), go to IDLE.
  - BRK: decode as break (non-extended), go to IDLE.
  - EXT_BRK: decode as break (extended), go to IDLE.
  - SKIP: decrement skip count per byte; at 0 go to IDLE. No decode and no events in this state.
- Key map, P1 (non-extended): 1D up, 1B down, 1C left, 23 right, 29 bomb.
- Key map, P2: extended 75 up, 72 down, 6B left, 74 right; non-extended 5A bomb.
- Unmapped codes in any decode step: no state change beyond returning to IDLE, no event.
- Decode of a mapped key:
  - Make sets the key bit; break clears it.
  - Pushes {player,key,press} into the FIFO.
- Latency: byte_valid in cycle N -> keys bit and FIFO write visible in cycle N+1. event_valid rises in N+1 if the FIFO was empty. No combinational path from byte_in to any output.
- Timeout:
  - The counter runs only in EXT, BRK, EXT_BRK and SKIP, and resets on every byte_valid.
  - Reaching TIMEOUT_CYCLES-1 -> go to IDLE, pulse proto_err; key vectors are unchanged.
  - If byte_valid and expiry occur in the same cycle, the byte wins: it is processed in the current state and no error is raised.
- FIFO:
  - Push when full without a simultaneous pop -> event dropped, overflow pulses, key vectors still updated.
  - Push and pop in the same cycle while full -> both performed, no overflow.
  - Pop when empty -> ignored.
  - Pointers wrap modulo FIFO_DEPTH. The head fields are registered outputs, held stable while event_valid && !event_ready.
- Reset asserted mid-sequence (e.g. after E0) -> all state cleared immediately; the next byte is decoded from IDLE.

Optional Feature:
- Macro: KEY_REPEAT_FILTER_EN.
- Defined: a make for a key whose bit is already set (typematic repeat) produces no FIFO event; a break for a key already clear produces no event. Key vectors behave identically in both cases.
- Undefined: every mapped make and break pushes an event, including typematic repeats.

Test Plan:
- Bytes 1D, then F0 1D -> p1_keys = 00001 one cycle after 1D, back to 00000 after 1D of the break. FIFO yields (P1,up,press) then (P1,up,release).
- Bytes E0 75, then E0 F0 75 -> p2_keys[0] set then cleared. Events (P2,up,1) then (P2,up,0). A bare 75 without E0 produces nothing.
- E1 14 77 E1 F0 14 F0 77, then 29 -> no events during the pause sequence; then p1_keys = 10000 and (P1,bomb,1).
- E0 followed by silence for TIMEOUT_CYCLES (set to 16 in test) -> proto_err pulse after 16 cycles. A following 6B decodes as non-extended unmapped -> no event.
- event_ready held 0, 5 distinct mapped makes with FIFO_DEPTH 4 -> one overflow pulse on the 5th. All 5 key bits set. Draining yields the first 4 in order.
- 1C sent three times -> with KEY_REPEAT_FILTER_EN 1 event, without it 3 events; p1_keys[2] = 1 in both builds.
